quadrature_encoder_gen: RTL

Generates two-phase quadrature signals (A/B) like a mechanical rotary encoder, driven by step commands over a valid/ready handshake. It is the transmit side of the rotary-encoder input path.
It serves as an on-board stimulus source: loop it into gpio or directly into the debounce and decoder chain.
Optional contact-bounce injection exercises sync_and_debounce.

---
 rtl/quadrature_pkg.sv | 31 +++
 rtl/quad_edge_timer.sv | 61 ++++++
 rtl/quadrature_encoder_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/quadrature_pkg.sv
// Shared types and constants for the quadrature encoder generator.
//   state_e    : controller states
//   PHASE_AB   : phase index p -> {a,b} line levels
//   DIR_CW/CCW : command direction encodings
//   phase_step : next phase index for one edge in a given direction
package quadrature_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Gray sequence: index 0..3 -> 00, 10, 11, 01 (index 3 is the MSB slice)
    localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    function automatic logic [1:0] phase_step(input logic [1:0] p, input logic dir);
        logic [1:0] p_next;
        if (dir == DIR_CCW) begin
            p_next = p - 2'd1;
        end else begin
            p_next = p + 2'd1;
        end
        return p_next;
    endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// Loadable down-counter that ticks every (reload_val + 1) cycles while enabled.
//   clk, rst_n   : clock, async active-low reset
//   en           : count enable
//   load         : load load_val into the counter and clear the offset (priority over en)
//   load_val     : value loaded by load
//   reload_val   : value reloaded automatically on a tick
//   tick         : counter is at zero while enabled
//   offset       : cycles since the last tick/load, saturating
module quad_edge_timer
    import quadrature_pkg::*;
#(
    parameter int w_period = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [w_period-1:0] load_val,
    input  logic [w_period-1:0] reload_val,
    output logic                tick,
    output logic [w_period-1:0] offset
);

    localparam logic [w_period-1:0] ONE = w_period'(1);

    logic [w_period-1:0] cnt_q, cnt_d;
    logic [w_period-1:0] offset_q, offset_d;

    assign tick   = en && (cnt_q == '0);
    assign offset = offset_q;

    always_comb begin
        cnt_d    = cnt_q;
        offset_d = offset_q;
        if (load) begin
            cnt_d    = load_val;
            offset_d = '0;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d    = reload_val;
                offset_d = '0;
            end else begin
                cnt_d = cnt_q - ONE;
                if (offset_q != '1) begin
                    offset_d = offset_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B generator driven by step commands (valid/ready).
// Each accepted command emits cmd_steps edges spaced cmd_period cycles apart,
// settles for one more period, then pulses done. Optional contact bounce
// flips the toggling line back for bounce_n single cycles after each edge.
//   clk, rst_n            : clock, async active-low reset
//   cmd_valid / cmd_ready : command handshake (ready only in IDLE)
//   cmd_dir               : 1 = cw (A leads B), 0 = ccw
//   cmd_steps             : number of edges to emit
//   cmd_period            : cycles between edges, 0 treated as 1
//   abort                 : end the active command early
//   a, b                  : quadrature lines
//   busy                  : command in progress (RUN/SETTLE)
//   done                  : one-cycle completion pulse
//   position              : signed edge count, wraps
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// RUN    | emitting edges every period cycles
// SETTLE | last edge emitted, waiting out the final period
// DONE   | one-cycle done pulse, then back to IDLE
module quadrature_encoder_gen
    import quadrature_pkg::*;
#(
    parameter int w_steps  = 16,
    parameter int w_period = 16,
    parameter int w_pos    = 16,
    parameter int bounce_n = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [w_steps-1:0]  cmd_steps,
    input  logic [w_period-1:0] cmd_period,
    input  logic                abort,
    output logic                a,
    output logic                b,
    output logic                busy,
    output logic                done,
    output logic [w_pos-1:0]    position
);

    localparam logic [w_period-1:0] PER_ONE   = w_period'(1);
    localparam logic [w_period-1:0] PER_TWO   = w_period'(2);
    localparam logic [w_steps-1:0]  STEPS_ONE = w_steps'(1);
    localparam logic [w_pos-1:0]    POS_ONE   = w_pos'(1);
    localparam int                  BOUNCE_LIM = 2 * bounce_n;

    state_e              state_q, state_d;
    logic [1:0]          p_q, p_d;
    logic [w_pos-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [w_steps-1:0]  steps_left_q, steps_left_d;
    logic [w_period-1:0] period_q, period_d;
    logic                bounce_active_q, bounce_active_d;
    logic                bounce_on_a_q, bounce_on_a_d;

    logic                accept;
    logic                edge_now;
    logic                last_edge;
    logic [w_period-1:0] period_eff;
    logic                timer_en;
    logic                timer_load;
    logic [w_period-1:0] timer_load_val;
    logic                tick;
    logic [w_period-1:0] offset;
    logic                flip;
    logic [1:0]          ab_settled;

    assign period_eff = (cmd_period == '0) ? PER_ONE : cmd_period;
    assign accept     = (state_q == ST_IDLE) && cmd_valid;
    assign edge_now   = (state_q == ST_RUN) && tick;
    assign last_edge  = edge_now && (steps_left_q == STEPS_ONE);
    assign timer_en   = (state_q == ST_RUN) || (state_q == ST_SETTLE);

    // The final edge reloads period-2 so that, counting the DONE cycle itself,
    // done lands exactly one period after the last edge.
    assign timer_load     = accept || last_edge;
    assign timer_load_val = accept ? (period_eff - PER_ONE) : (period_q - PER_TWO);

    quad_edge_timer #(
        .w_period (w_period)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (timer_en),
        .load       (timer_load),
        .load_val   (timer_load_val),
        .reload_val (period_q - PER_ONE),
        .tick       (tick),
        .offset     (offset)
    );

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        pos_d         = pos_q;
        dir_d         = dir_q;
        steps_left_d  = steps_left_q;
        period_d      = period_q;
        bounce_on_a_d = bounce_on_a_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d        = cmd_dir;
                    steps_left_d = cmd_steps;
                    period_d     = period_eff;
                    state_d      = (cmd_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (edge_now) begin
                    p_d           = phase_step(p_q, dir_q);
                    pos_d         = (dir_q == DIR_CW) ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                    steps_left_d  = steps_left_q - STEPS_ONE;
                    bounce_on_a_d = PHASE_AB[p_q][1] ^ PHASE_AB[p_d][1];
                    if (last_edge) begin
                        state_d = (period_q == PER_ONE) ? ST_DONE : ST_SETTLE;
                    end
                end
                if (abort) begin
                    state_d = ST_DONE;
                end
            end
            ST_SETTLE: begin
                if (tick || abort) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bounce lives only while the command is active; leaving RUN/SETTLE
        // snaps the line to its settled level.
        bounce_active_d = (bounce_n > 0)
                       && ((state_d == ST_RUN) || (state_d == ST_SETTLE))
                       && (edge_now || bounce_active_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            p_q             <= 2'd0;
            pos_q           <= '0;
            dir_q           <= DIR_CW;
            steps_left_q    <= '0;
            period_q        <= '0;
            bounce_active_q <= 1'b0;
            bounce_on_a_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            p_q             <= p_d;
            pos_q           <= pos_d;
            dir_q           <= dir_d;
            steps_left_q    <= steps_left_d;
            period_q        <= period_d;
            bounce_active_q <= bounce_active_d;
            bounce_on_a_q   <= bounce_on_a_d;
        end
    end

    // Odd offsets below 2*bounce_n show the old level; the offset restarts on
    // every edge, which truncates any unfinished bounce.
    assign flip       = bounce_active_q && offset[0] && (int'(offset) < BOUNCE_LIM);
    assign ab_settled = PHASE_AB[p_q];

    assign a         = ab_settled[1] ^ (flip & bounce_on_a_q);
    assign b         = ab_settled[0] ^ (flip & ~bounce_on_a_q);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign done      = (state_q == ST_DONE);
    assign cmd_ready = (state_q == ST_IDLE);
    assign position  = pos_q;

endmodule
